// File: rtl/vend_session_ctrl.sv
// Vending session controller: credit register, dispense, inactivity timer and greedy change return.
// Optional VEND_AVAILABLE_EN adds a registered per-item "affordable" output.
module vend_session_ctrl #(
   parameter int kNumCoins   = 3,
   parameter int kNumItems   = 4,
   parameter int kTotalBits  = 31,
   parameter int kWaitTime   = 10,
   parameter int COIN_VAL0   = 100,
   parameter int COIN_VAL1   = 500,
   parameter int COIN_VAL2   = 1000,
   parameter int ITEM_PRICE0 = 400,
   parameter int ITEM_PRICE1 = 500,
   parameter int ITEM_PRICE2 = 1000,
   parameter int ITEM_PRICE3 = 2000,
   parameter int MAX_TOTAL   = 10000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [kNumCoins-1:0]  i_input_coin,
   input  logic [kNumItems-1:0]  i_select_item,
   input  logic                  i_trigger_return,
   output logic [kNumItems-1:0]  o_output_item,
   output logic [kNumCoins-1:0]  o_return_coin,
   output logic                  o_reject_coin,
   output logic [kTotalBits-1:0] o_current_total,
`ifdef VEND_AVAILABLE_EN
   output logic [kNumItems-1:0]  o_available_item,
`endif
   output logic                  o_busy
);

   // state     | meaning
   // ST_IDLE   | no credit held, waiting for a coin
   // ST_CREDIT | credit held, accepting coins/selections, wait timer running
   // ST_RETURN | paying change back one coin per cycle, largest first

   localparam int kWaitBits = $clog2(kWaitTime + 1);
   localparam logic [kTotalBits-1:0] kCoinVal [kNumCoins] =
      '{kTotalBits'(COIN_VAL0), kTotalBits'(COIN_VAL1), kTotalBits'(COIN_VAL2)};
   localparam logic [kTotalBits-1:0] kItemPrice [kNumItems] =
      '{kTotalBits'(ITEM_PRICE0), kTotalBits'(ITEM_PRICE1),
        kTotalBits'(ITEM_PRICE2), kTotalBits'(ITEM_PRICE3)};
   localparam logic [kTotalBits:0] kMaxTotal = (kTotalBits + 1)'(MAX_TOTAL);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_RETURN = 2'd2
   } state_t;

   state_t                state, state_nx;
   logic [kTotalBits-1:0] total, total_nx;
   logic [kTotalBits-1:0] coin_amt, price, ret_amt;
   logic [kWaitBits-1:0]  wait_time, wait_nx;
   logic [kNumItems-1:0]  item_nx;
   logic [kNumCoins-1:0]  ret_nx, ret_oh;
   logic                  rej_nx;
   logic                  coin_valid, select_valid, coin_fits, accept, dispense;

   always_comb begin : decode
      coin_amt = '0;
      price    = '0;
      ret_amt  = '0;
      ret_oh   = '0;
      for (int k = 0; k < kNumCoins; k++) begin
         if (i_input_coin[k]) coin_amt = kCoinVal[k];
         // ascending scan, so the largest denomination that fits wins
         if (kCoinVal[k] <= total) begin
            ret_amt   = kCoinVal[k];
            ret_oh    = '0;
            ret_oh[k] = 1'b1;
         end
      end
      for (int j = 0; j < kNumItems; j++) begin
         if (i_select_item[j]) price = kItemPrice[j];
      end
   end

   assign coin_valid   = $onehot(i_input_coin);
   assign select_valid = $onehot(i_select_item);
   assign coin_fits    = ({1'b0, total} + {1'b0, coin_amt}) <= kMaxTotal;
   assign accept       = coin_valid && coin_fits && (state != ST_RETURN);
   assign dispense     = (state == ST_CREDIT) && select_valid && !i_trigger_return
                         && (total >= price);

   always_comb begin : fsm_next
      state_nx = state;
      total_nx = total;
      wait_nx  = '0;
      item_nx  = '0;
      ret_nx   = '0;
      rej_nx   = coin_valid && !accept;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = ST_CREDIT;
               total_nx = total + coin_amt;
            end
         end
         ST_CREDIT: begin
            total_nx = total + (accept ? coin_amt : '0) - (dispense ? price : '0);
            if (dispense) item_nx = i_select_item;
            if (i_trigger_return) begin
               state_nx = ST_RETURN;
            end else if (accept || dispense) begin
               if (total_nx == '0) state_nx = ST_IDLE;
            end else if (wait_time == kWaitBits'(kWaitTime - 1)) begin
               state_nx = ST_RETURN;
            end else if (wait_time != kWaitBits'(kWaitTime)) begin
               wait_nx = wait_time + kWaitBits'(1);
            end else begin
               wait_nx = wait_time;
            end
         end
         ST_RETURN: begin
            // linger one cycle at zero so busy covers the final coin pulse
            if (total == '0) begin
               state_nx = ST_IDLE;
            end else begin
               total_nx = total - ret_amt;
               ret_nx   = ret_oh;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         total         <= '0;
         wait_time     <= '0;
         o_output_item <= '0;
         o_return_coin <= '0;
         o_reject_coin <= 1'b0;
      end else begin
         state         <= state_nx;
         total         <= total_nx;
         wait_time     <= wait_nx;
         o_output_item <= item_nx;
         o_return_coin <= ret_nx;
         o_reject_coin <= rej_nx;
      end
   end

`ifdef VEND_AVAILABLE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_available_item <= '0;
      end else begin
         for (int j = 0; j < kNumItems; j++) begin
            o_available_item[j] <= (total >= kItemPrice[j]) && (state != ST_RETURN);
         end
      end
   end
`endif

   assign o_current_total = total;
   assign o_busy          = (state == ST_RETURN);

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Self-checking bench for vend_session_ctrl: directed scenarios plus randomized traffic
// against a credit/change-queue reference model.
module tb_vend_session_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  i_input_coin;
   logic [3:0]  i_select_item;
   logic        i_trigger_return;
   logic [3:0]  o_output_item;
   logic [2:0]  o_return_coin;
   logic        o_reject_coin;
   logic [30:0] o_current_total;
   logic        o_busy;
`ifdef VEND_AVAILABLE_EN
   logic [3:0]  o_available_item;
`endif

   int checks = 0;
   int errors = 0;

   int cval [3] = '{100, 500, 1000};
   int pval [4] = '{400, 500, 1000, 2000};

   // reference model: mode follows from total (zero = idle) plus a returning flag
   int   m_total;
   int   m_wait;
   bit   m_ret;
   int   m_owed [$];
   logic [3:0] exp_item;
   logic [2:0] exp_ret;
   logic       exp_rej;
   logic [3:0] exp_avail;

   vend_session_ctrl dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_reject_coin    (o_reject_coin),
      .o_current_total  (o_current_total),
`ifdef VEND_AVAILABLE_EN
      .o_available_item (o_available_item),
`endif
      .o_busy           (o_busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_total = 0;
      m_wait  = 0;
      m_ret   = 0;
      m_owed.delete();
      exp_item  = '0;
      exp_ret   = '0;
      exp_rej   = 1'b0;
      exp_avail = '0;
   endtask

   task automatic model_update(input logic [2:0] c, input logic [3:0] s, input logic t);
      int  cv, pr, nt, amt;
      bit  act;
      for (int j = 0; j < 4; j++) exp_avail[j] = (m_total >= pval[j]) && !m_ret;
      exp_item = '0;
      exp_ret  = '0;
      exp_rej  = 1'b0;
      cv = 0;
      pr = 0;
      for (int k = 0; k < 3; k++) if (c[k]) cv = cval[k];
      for (int j = 0; j < 4; j++) if (s[j]) pr = pval[j];
      if (m_ret) begin
         exp_rej = ($countones(c) == 1);
         if (m_owed.size() > 0) begin
            int k;
            k = m_owed.pop_front();
            exp_ret[k] = 1'b1;
            m_total -= cval[k];
         end else begin
            m_ret = 0;
         end
      end else begin
         nt  = m_total;
         act = 0;
         if ($countones(c) == 1) begin
            if (m_total + cv <= 10000) begin nt += cv; act = 1; end
            else exp_rej = 1'b1;
         end
         if (m_total > 0 && !t && $countones(s) == 1 && m_total >= pr) begin
            nt -= pr;
            exp_item = s;
            act = 1;
         end
         if (m_total > 0) begin
            if (t || (!act && m_wait == 9)) begin
               m_ret  = 1;
               m_wait = 0;
               amt = nt;
               for (int k = 2; k >= 0; k--) begin
                  while (amt >= cval[k]) begin m_owed.push_back(k); amt -= cval[k]; end
               end
            end else if (act) begin
               m_wait = 0;
            end else begin
               m_wait++;
            end
         end
         m_total = nt;
      end
   endtask

   task automatic step(input logic [2:0] c, input logic [3:0] s, input logic t);
      i_input_coin     = c;
      i_select_item    = s;
      i_trigger_return = t;
      model_update(c, s, t);
      @(posedge clk);
      #1;
      i_input_coin     = '0;
      i_select_item    = '0;
      i_trigger_return = 1'b0;
   endtask

   // pays out any held credit; bounded by a cycle budget
   task automatic drain();
      if (m_total > 0 && !m_ret) step(3'b000, 4'b0000, 1'b1);
      for (int i = 0; i < 40 && m_ret; i++) step(3'b000, 4'b0000, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      i_input_coin = '0; i_select_item = '0; i_trigger_return = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({o_output_item, o_return_coin, o_reject_coin, o_busy} !== 9'b0 || o_current_total !== 31'd0) begin
         errors++;
         $display("FAIL reset_outputs: item=%b ret=%b rej=%b busy=%b total=%0d, required all 0",
                  o_output_item, o_return_coin, o_reject_coin, o_busy, o_current_total);
      end
      reset_n = 1'b1;
      step(3'b000, 4'b0000, 1'b0);
      checks++;
      if (o_current_total !== 31'd0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: total=%0d busy=%b, required 0/0", o_current_total, o_busy);
      end
   endtask

   task automatic test_credit();
      step(3'b100, 4'b0000, 1'b0);
      step(3'b010, 4'b0000, 1'b0);
      checks++;
      if (o_current_total !== 31'd1500 || o_busy !== 1'b0 ||
          {o_output_item, o_return_coin, o_reject_coin} !== 8'b0) begin
         errors++;
         $display("FAIL credit_1500: total=%0d busy=%b item=%b ret=%b rej=%b, required 1500 and quiet outputs",
                  o_current_total, o_busy, o_output_item, o_return_coin, o_reject_coin);
      end
   endtask

   task automatic test_dispense();
      step(3'b000, 4'b0010, 1'b0);
      checks++;
      if (o_output_item !== 4'b0010 || o_current_total !== 31'd1000) begin
         errors++;
         $display("FAIL dispense_item1: item=%b total=%0d, required 0010/1000", o_output_item, o_current_total);
      end
      step(3'b000, 4'b0000, 1'b0);
      checks++;
      if (o_output_item !== 4'b0000) begin
         errors++;
         $display("FAIL dispense_pulse: item=%b, required 0000", o_output_item);
      end
      step(3'b000, 4'b1000, 1'b0);
      checks++;
      if (o_output_item !== 4'b0000 || o_current_total !== 31'd1000) begin
         errors++;
         $display("FAIL dispense_short: item=%b total=%0d, required 0000/1000", o_output_item, o_current_total);
      end
   endtask

   task automatic test_return();
      logic [2:0] seq [3];
      seq = '{3'b100, 3'b010, 3'b001};
      step(3'b010, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      step(3'b000, 4'b0000, 1'b1);
      checks++;
      if (o_busy !== 1'b1 || o_return_coin !== 3'b000 || o_current_total !== 31'd1600) begin
         errors++;
         $display("FAIL return_entry: busy=%b ret=%b total=%0d, required 1/000/1600",
                  o_busy, o_return_coin, o_current_total);
      end
      for (int i = 0; i < 3; i++) begin
         step(3'b000, 4'b0000, 1'b0);
         checks++;
         if (o_return_coin !== seq[i] || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL return_coin%0d: ret=%b busy=%b, required %b/1", i, o_return_coin, o_busy, seq[i]);
         end
      end
      step(3'b000, 4'b0000, 1'b0);
      checks++;
      if (o_busy !== 1'b0 || o_current_total !== 31'd0 || o_return_coin !== 3'b000) begin
         errors++;
         $display("FAIL return_done: busy=%b total=%0d ret=%b, required 0/0/000",
                  o_busy, o_current_total, o_return_coin);
      end
   endtask

   task automatic test_timeout();
      step(3'b001, 4'b0000, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(3'b000, 4'b0000, 1'b0);
         checks++;
         if (o_busy !== (i == 10)) begin
            errors++;
            $display("FAIL timeout_idle%0d: busy=%b, required %b", i, o_busy, (i == 10));
         end
      end
      step(3'b000, 4'b0000, 1'b0);
      checks++;
      if (o_return_coin !== 3'b001 || o_current_total !== 31'd0) begin
         errors++;
         $display("FAIL timeout_coin: ret=%b total=%0d, required 001/0", o_return_coin, o_current_total);
      end
      drain();
      step(3'b001, 4'b0000, 1'b0);
      for (int i = 1; i <= 8; i++) step(3'b000, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(3'b000, 4'b0000, 1'b0);
         checks++;
         if (o_busy !== (i == 10)) begin
            errors++;
            $display("FAIL timeout_restart%0d: busy=%b, required %b", i, o_busy, (i == 10));
         end
      end
      drain();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 9; i++) step(3'b100, 4'b0000, 1'b0);
      step(3'b010, 4'b0000, 1'b0);
      step(3'b100, 4'b0000, 1'b0);
      checks++;
      if (o_reject_coin !== 1'b1 || o_current_total !== 31'd9500) begin
         errors++;
         $display("FAIL overflow_reject: rej=%b total=%0d, required 1/9500", o_reject_coin, o_current_total);
      end
      step(3'b000, 4'b0000, 1'b0);
      checks++;
      if (o_reject_coin !== 1'b0) begin
         errors++;
         $display("FAIL overflow_pulse: rej=%b, required 0", o_reject_coin);
      end
      drain();
      checks++;
      if (o_busy !== 1'b0 || o_current_total !== 31'd0) begin
         errors++;
         $display("FAIL overflow_drain: busy=%b total=%0d, required 0/0", o_busy, o_current_total);
      end
      for (int i = 0; i < 4; i++) step(3'b001, 4'b0000, 1'b0);
      step(3'b001, 4'b0001, 1'b0);
      checks++;
      if (o_output_item !== 4'b0001 || o_current_total !== 31'd100) begin
         errors++;
         $display("FAIL coin_and_select: item=%b total=%0d, required 0001/100", o_output_item, o_current_total);
      end
      drain();
   endtask

   task automatic test_multihot();
      step(3'b011, 4'b0000, 1'b0);
      checks++;
      if (o_reject_coin !== 1'b0 || o_current_total !== 31'd0) begin
         errors++;
         $display("FAIL multihot_coin_idle: rej=%b total=%0d, required 0/0", o_reject_coin, o_current_total);
      end
      step(3'b100, 4'b0000, 1'b0);
      step(3'b110, 4'b0011, 1'b0);
      checks++;
      if (o_reject_coin !== 1'b0 || o_output_item !== 4'b0000 || o_current_total !== 31'd1000) begin
         errors++;
         $display("FAIL multihot_credit: rej=%b item=%b total=%0d, required 0/0000/1000",
                  o_reject_coin, o_output_item, o_current_total);
      end
      step(3'b000, 4'b0001, 1'b1);
      checks++;
      if (o_output_item !== 4'b0000 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL return_priority: item=%b busy=%b, required 0000/1", o_output_item, o_busy);
      end
      step(3'b010, 4'b0000, 1'b0);
      checks++;
      if (o_reject_coin !== 1'b1 || o_return_coin !== 3'b100) begin
         errors++;
         $display("FAIL return_reject: rej=%b ret=%b, required 1/100", o_reject_coin, o_return_coin);
      end
      drain();
   endtask

   task automatic test_reset_mid_return();
      step(3'b010, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      step(3'b000, 4'b0000, 1'b1);
      step(3'b000, 4'b0000, 1'b0);
      checks++;
      if (o_return_coin !== 3'b010 || o_current_total !== 31'd200) begin
         errors++;
         $display("FAIL mid_return_setup: ret=%b total=%0d, required 010/200", o_return_coin, o_current_total);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({o_output_item, o_return_coin, o_reject_coin, o_busy} !== 9'b0 || o_current_total !== 31'd0) begin
         errors++;
         $display("FAIL async_reset: ret=%b busy=%b total=%0d, required 000/0/0",
                  o_return_coin, o_busy, o_current_total);
      end
      #2 reset_n = 1'b1;
      model_reset();
      step(3'b000, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      checks++;
      if (o_busy !== 1'b0 || o_current_total !== 31'd100 || o_return_coin !== 3'b000) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b total=%0d ret=%b, required 0/100/000",
                  o_busy, o_current_total, o_return_coin);
      end
      drain();
   endtask

   task automatic test_random();
      logic [2:0] c;
      logic [3:0] s;
      logic       t;
      int         r;
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4)       c = 3'b001 << $urandom_range(0, 2);
         else if (r == 4) c = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b101;
         else             c = 3'b000;
         r = $urandom_range(0, 9);
         if (r < 3)       s = 4'b0001 << $urandom_range(0, 3);
         else if (r == 3) s = 4'b0110;
         else             s = 4'b0000;
         t = ($urandom_range(0, 24) == 0);
         step(c, s, t);
         checks++;
         if (o_output_item !== exp_item || o_return_coin !== exp_ret || o_reject_coin !== exp_rej ||
             o_busy !== m_ret || o_current_total !== 31'(m_total)) begin
            errors++;
            $display("FAIL random_cycle%0d: item=%b ret=%b rej=%b busy=%b total=%0d, required %b/%b/%b/%b/%0d",
                     n, o_output_item, o_return_coin, o_reject_coin, o_busy, o_current_total,
                     exp_item, exp_ret, exp_rej, m_ret, m_total);
         end
`ifdef VEND_AVAILABLE_EN
         checks++;
         if (o_available_item !== exp_avail) begin
            errors++;
            $display("FAIL random_avail%0d: avail=%b, required %b", n, o_available_item, exp_avail);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_credit();
      test_dispense();
      test_return();
      test_timeout();
      test_overflow();
      test_multihot();
      test_reset_mid_return();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_session_ctrl.md
Name: vend_session_ctrl

Overview:
- Top-level vending session controller.
- Accepts one-hot coin pulses and one-hot item selections, and keeps the running credit total.
- Dispenses items when credit is sufficient.
- On explicit return request or inactivity timeout, pays the remaining credit back one coin per cycle, largest coin first.
- Sits between the front-panel input synchronisers and the coin/item actuator drivers; it owns the credit register and the wait timer.

Parameters:
- kNumCoins, 3, number of coin denominations (index 0 = smallest).
- kNumItems, 4, number of selectable items.
- kTotalBits, 31, width of the credit total.
- kWaitTime, 10, idle cycles in CREDIT before auto-return.
- COIN_VAL0/1/2, 100/500/1000, coin denominations; each must be a multiple of COIN_VAL0.
- ITEM_PRICE0/1/2/3, 400/500/1000/2000, item prices; each must be a multiple of COIN_VAL0.
- MAX_TOTAL, 10000, credit ceiling.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  async active-low reset.
- i_input_coin  in  kNumCoins  one-hot coin-inserted pulse.
- i_select_item  in  kNumItems  one-hot item-request pulse.
- i_trigger_return  in  1  return-change request.
- o_output_item  out  kNumItems  one-hot dispense pulse, registered.
- o_return_coin  out  kNumCoins  one-hot coin-eject pulse, registered.
- o_reject_coin  out  1  inserted coin not credited, registered pulse.
- o_current_total  out  kTotalBits  credit register.
- o_busy  out  1  high while in RETURN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; total=0; wait_time=0.
  - All outputs 0.
  - Reset mid-RETURN drops the owed change.
- States: IDLE (total==0), CREDIT (total>0), RETURN.
- Input validity:
  - A multi-hot i_input_coin is ignored; no credit, no reject.
  - A multi-hot i_select_item is ignored.
- Coin accept (IDLE/CREDIT):
  - Valid coin k with total+COIN_VALk <= MAX_TOTAL: credited at next edge.
  - Otherwise: o_reject_coin=1 for one cycle, total unchanged.
- Dispense (CREDIT):
  - Select j with total >= ITEM_PRICEj (total sampled before any same-cycle coin): next cycle o_output_item[j]=1 for one cycle, total -= price.
  - Insufficient credit: no output, no state change.
- Same-cycle coin+select: next total = total + coin - price (if dispensed). Both events count as activity.
- Wait timer:
  - Counts only in CREDIT.
  - Cleared by an accepted coin or a dispense; otherwise +1 per cycle.
  - Saturates at kWaitTime.
- Transitions:
  - IDLE->CREDIT: accepted coin.
  - CREDIT->IDLE: total reaches 0 via dispense.
  - CREDIT->RETURN: i_trigger_return, or wait_time==kWaitTime-1 with no activity this cycle.
  - RETURN is entered at the next edge; i_trigger_return has priority over a same-cycle select, which is ignored.
  - i_trigger_return in IDLE or RETURN: no effect.
- RETURN:
  - Each cycle, o_return_coin = one-hot of the largest k with COIN_VALk <= total, and total -= COIN_VALk.
  - First coin appears one cycle after entry.
  - When total hits 0: next state IDLE, o_busy low, wait_time=0.
  - Coins and selects in RETURN: coins are rejected via o_reject_coin; selects are ignored.
- Arithmetic: unsigned, kTotalBits wide. The MAX_TOTAL check prevents overflow; underflow is impossible by construction.

Optional Feature:
- Macro: VEND_AVAILABLE_EN.
- Defined:
  - Adds output o_available_item [kNumItems], registered.
  - Bit j is set when total >= ITEM_PRICEj and state != RETURN.
  - Updates one cycle after total changes; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then insert coin2 (1000) and coin1 (500) in consecutive cycles -> total=1500, state CREDIT, no outputs.
- Total=1500, select item1 (500) -> o_output_item=0010 for 1 cycle, total=1000; then select item3 (2000) -> no output, total stays 1000.
- Total=1600, pulse i_trigger_return -> o_return_coin sequence 100(b), 010, 001 on 3 consecutive cycles, o_busy high throughout, then IDLE with total=0.
- Timeout:
  - Insert coin0 (100), idle 10 cycles -> RETURN entered after cycle 10, o_return_coin=001 once.
  - A coin on cycle 9 restarts the count.
- Total=9500, insert coin2 -> o_reject_coin pulse, total 9500; then same-cycle coin0+select item0 at total=400 -> dispense item0, total=100.
- Assert reset_n low mid-RETURN (total=700) -> outputs and total clear immediately without a clock edge; after release, state is IDLE.
